// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: feeder FSM states and the
// default operand width / buffer depth / MAC latency used by mac and mac_feeder.
package mac_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feeder_state_e;

    localparam int MAC_WIDTH   = 16;
    localparam int MAC_DEPTH   = 8;
    localparam int MAC_LATENCY = 1;

    // Width of the drain counter. The counter holds at most MAC_LAT-2 because
    // the RUN->DRAIN edge and the final DRAIN edge already cover two MAC edges.
    function automatic int drain_w(input int lat);
        return (lat > 2) ? $clog2(lat - 1) : 1;
    endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// Operand-pair write port of the MAC feeder (valid/ready handshake).
interface mac_feeder_if
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
);
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_a;
    logic [WIDTH-1:0] wr_b;

    modport master (output wr_valid, output wr_a, output wr_b, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_a, input  wr_b, output wr_ready);
endinterface

// File: rtl/mac_feeder_buf.sv
// Operand-pair register file: one synchronous write port, one combinational
// read port. Contents are not reset; the feeder never reads an unwritten slot.
module mac_feeder_buf
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int DEPTH = MAC_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [2*WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [2*WIDTH-1:0]         rdata
);

    logic [2*WIDTH-1:0] mem_q [DEPTH];

    // Store the offered pair in the addressed slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mac_feeder.sv
// Operand stage ahead of the MAC: collects up to DEPTH pairs, streams them one
// per clock on start, drives zeros otherwise, then flags when MAC op is final.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int WIDTH   = MAC_WIDTH,
    parameter int DEPTH   = MAC_DEPTH,
    parameter int MAC_LAT = MAC_LATENCY
) (
    input  logic                       clk,
    input  logic                       rst,
    mac_feeder_if.slave                wr,
    input  logic                       start,
    output logic                       busy,
    output logic [WIDTH-1:0]           a_out,
    output logic [WIDTH-1:0]           b_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       res_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = drain_w(MAC_LAT);

    feeder_state_e     state_q,     state_d;
    logic [CW-1:0]     count_q,     count_d;
    logic [CW-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [DW-1:0]     drain_q,     drain_d;
    logic [WIDTH-1:0]  a_q,         a_d;
    logic [WIDTH-1:0]  b_q,         b_d;
    logic              res_valid_q, res_valid_d;
    logic              wr_ready_q,  wr_ready_d;

    logic              wr_fire;
    logic              buf_we;
    logic [AW-1:0]     buf_raddr;
    logic [2*WIDTH-1:0] buf_rdata;

    mac_feeder_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (count_q[AW-1:0]),
        .wdata ({wr.wr_a, wr.wr_b}),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    // wr_ready_q is only ever high in LOAD with room left, so it qualifies writes alone.
    assign wr_fire   = wr.wr_valid && wr_ready_q;
    assign buf_raddr = (state_q == RUN) ? rd_ptr_q[AW-1:0] : '0;

    // Next-state, pointer/counter updates and the registered MAC operands.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        drain_d     = drain_q;
        a_d         = '0;
        b_d         = '0;
        res_valid_d = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            LOAD: begin
                if (wr_fire) begin
                    buf_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
                // Pair 0 goes out on the start edge itself; a same-cycle write
                // into an empty buffer is not in the register file yet, so
                // forward it.
                if (start && (count_d != '0)) begin
                    state_d  = RUN;
                    rd_ptr_d = CW'(1);
                    if (count_q == '0) begin
                        a_d = wr.wr_a;
                        b_d = wr.wr_b;
                    end else begin
                        {a_d, b_d} = buf_rdata;
                    end
                end
            end
            RUN: begin
                if (rd_ptr_q == count_q) begin
                    // All pairs issued; operands fall back to zero this edge.
                    if (MAC_LAT == 1) begin
                        res_valid_d = 1'b1;
                        count_d     = '0;
                        rd_ptr_d    = '0;
                        state_d     = LOAD;
                    end else begin
                        drain_d = DW'(MAC_LAT - 2);
                        state_d = DRAIN;
                    end
                end else begin
                    {a_d, b_d} = buf_rdata;
                    rd_ptr_d   = rd_ptr_q + CW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    res_valid_d = 1'b1;
                    count_d     = '0;
                    rd_ptr_d    = '0;
                    state_d     = LOAD;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: begin
                state_d  = LOAD;
                count_d  = '0;
                rd_ptr_d = '0;
            end
        endcase

        wr_ready_d = (state_d == LOAD) && (count_d != CW'(DEPTH));
    end

    // State and output registers; reset aborts any run and zeroes the operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            drain_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            drain_q     <= drain_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            wr_ready_q  <= wr_ready_d;
        end
    end

    assign wr.wr_ready = wr_ready_q;
    assign busy        = (state_q != LOAD);
    assign a_out       = a_q;
    assign b_out       = b_q;
    assign count       = count_q;
    assign res_valid   = res_valid_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: directed and randomized loads/runs against a queue
// model of the buffer and a running-sum model of an attached latency-1 MAC.
module tb_mac_feeder;

    localparam int W = 16;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic [W-1:0]  a_out;
    logic [W-1:0]  b_out;
    logic [3:0]    count;
    logic          res_valid;

    logic          mac_clr;
    logic [47:0]   op;

    int            n_cmp = 0;
    int            n_err = 0;

    logic [W-1:0]  qa[$];
    logic [W-1:0]  qb[$];
    logic [47:0]   model_op;

    mac_feeder_if #(.WIDTH(W)) wif ();

    mac_feeder #(.WIDTH(W), .DEPTH(D), .MAC_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wif),
        .start     (start),
        .busy      (busy),
        .a_out     (a_out),
        .b_out     (b_out),
        .count     (count),
        .res_valid (res_valid)
    );

    always #5 clk = ~clk;

    // Behavioural MAC with one edge of latency, cleared by the bench.
    always @(posedge clk) begin
        if (mac_clr) op <= '0;
        else         op <= op + 48'(a_out) * 48'(b_out);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one pair for one cycle; the model accepts it if the buffer has room.
    task automatic write_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        wif.wr_valid = 1'b1;
        wif.wr_a     = a;
        wif.wr_b     = b;
        chk("wr_ready", wif.wr_ready, 64'(qa.size() < D));
        if (qa.size() < D) begin
            qa.push_back(a);
            qb.push_back(b);
        end
        @(negedge clk);
        wif.wr_valid = 1'b0;
    endtask

    // Start a run (optionally with a same-cycle write), check every issued
    // pair, the result pulse and the MAC sum. noisy keeps start/wr_valid high
    // throughout the run.
    task automatic do_run(input bit with_wr, input logic [W-1:0] wa, input logic [W-1:0] wb,
                          input bit noisy);
        int          n;
        logic [47:0] exp_op;
        start = 1'b1;
        if (with_wr) begin
            wif.wr_valid = 1'b1;
            wif.wr_a     = wa;
            wif.wr_b     = wb;
            if (qa.size() < D) begin
                qa.push_back(wa);
                qb.push_back(wb);
            end
        end
        n      = qa.size();
        exp_op = model_op;
        for (int i = 0; i < n; i++) exp_op += 48'(qa[i]) * 48'(qb[i]);
        @(negedge clk);
        start        = 1'b0;
        wif.wr_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (noisy) begin
                start        = 1'b1;
                wif.wr_valid = 1'b1;
                wif.wr_a     = W'($urandom);
                wif.wr_b     = W'($urandom);
            end
            chk("run_a", a_out, qa[i]);
            chk("run_b", b_out, qb[i]);
            chk("run_busy", busy, 1);
            chk("run_res_valid_early", res_valid, 0);
            chk("run_count", count, n);
        end
        @(negedge clk);
        start        = 1'b0;
        wif.wr_valid = 1'b0;
        chk("end_a_zero", a_out, 0);
        chk("end_b_zero", b_out, 0);
        chk("end_res_valid", res_valid, 1);
        chk("end_op", op, exp_op);
        chk("end_count", count, 0);
        chk("end_wr_ready", wif.wr_ready, 1);
        chk("end_busy", busy, 0);
        @(negedge clk);
        chk("post_res_valid", res_valid, 0);
        chk("post_a_zero", a_out, 0);
        model_op = exp_op;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        logic [47:0] op_before;
        int          n;

        rst          = 1'b0;
        mac_clr      = 1'b1;
        start        = 1'b0;
        wif.wr_valid = 1'b1;
        wif.wr_a     = '0;
        wif.wr_b     = '0;
        model_op     = '0;

        // Reset held for three cycles with a write offered.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wr_ready", wif.wr_ready, 0);
            chk("rst_a", a_out, 0);
            chk("rst_b", b_out, 0);
            chk("rst_count", count, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
        end
        rst          = 1'b1;
        mac_clr      = 1'b0;
        wif.wr_valid = 1'b0;
        @(negedge clk);
        chk("rel_wr_ready", wif.wr_ready, 1);
        chk("rel_count", count, 0);
        chk("rel_res_valid", res_valid, 0);

        // Basic three-pair run: 2*3 + 4*5 + 6*7 = 68.
        write_pair(16'd2, 16'd3);
        write_pair(16'd4, 16'd5);
        write_pair(16'd6, 16'd7);
        chk("basic_count", count, 3);
        do_run(1'b0, '0, '0, 1'b0);
        chk("basic_op_68", op, 68);

        // Ten writes into an eight-deep buffer: the last two are dropped.
        for (int i = 0; i < 10; i++) write_pair(W'($urandom), W'($urandom));
        chk("full_count", count, 8);
        chk("full_wr_ready", wif.wr_ready, 0);
        do_run(1'b0, '0, '0, 1'b0);

        // Write of (9,9) together with start on a buffer holding (1,1).
        write_pair(16'd1, 16'd1);
        op_before = model_op;
        do_run(1'b1, 16'd9, 16'd9, 1'b0);
        chk("simul_op_delta", op - op_before, 82);

        // Start on an empty buffer is ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("empty_start_busy", busy, 0);
        chk("empty_start_count", count, 0);
        chk("empty_start_a", a_out, 0);
        @(negedge clk);
        chk("empty_start_busy2", busy, 0);

        // start and wr_valid held high during a run change nothing.
        for (int i = 0; i < 3; i++) write_pair(W'($urandom), W'($urandom));
        do_run(1'b0, '0, '0, 1'b1);

        // Randomized loads with gaps and overfills.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 10);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 2) == 0) @(negedge clk);
                write_pair(W'($urandom), W'($urandom));
            end
            chk("rand_count", count, qa.size());
            do_run(1'b0, '0, '0, it[0]);
        end

        // Reset during the second of four pairs aborts the run.
        for (int i = 0; i < 4; i++) write_pair(W'($urandom_range(1, 65535)), W'($urandom_range(1, 65535)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_pair0", a_out, qa[0]);
        @(negedge clk);
        chk("abort_pair1", a_out, qa[1]);
        rst = 1'b0;
        #1;
        chk("abort_a_zero", a_out, 0);
        chk("abort_b_zero", b_out, 0);
        chk("abort_count", count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_hold_res_valid", res_valid, 0);
            chk("abort_hold_a", a_out, 0);
        end
        rst     = 1'b1;
        mac_clr = 1'b1;
        qa.delete();
        qb.delete();
        model_op = '0;
        @(negedge clk);
        mac_clr = 1'b0;
        chk("abort_rel_wr_ready", wif.wr_ready, 1);
        chk("abort_rel_count", count, 0);
        chk("abort_rel_busy", busy, 0);
        chk("abort_rel_res_valid", res_valid, 0);

        // Recovery run after the abort.
        write_pair(16'd3, 16'd5);
        write_pair(16'd7, 16'd11);
        do_run(1'b0, '0, '0, 1'b0);
        chk("recover_op", op, 92);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
